mem_req_adapter: RTL and testbench
==================================

Name: mem_req_adapter

Overview:
Bridges a valid/ready byte-addressed request/response bus onto the single read/write port (port A) of the on-chip memory. It performs word-address translation, checks range and alignment, and accounts for the memory's one-cycle registered read latency. Responses are buffered in a small FIFO, so backpressure on the response channel never stalls or drops memory read data. It sits directly upstream of the memory, between the core/interconnect and the memory port.

Parameters:
WIDTH, 32, data width in bits; multiple of 8; must equal the memory WIDTH.
DEPTH, 256, memory depth in words; must equal the memory DEPTH.
ADDR_W, 32, request byte-address width.
RSP_DEPTH, 4, response FIFO entries; minimum 2; a value of 3 or more sustains one request per cycle.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  asynchronous reset, active-high.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request ready.
req_we_i  in  1  1 = write, 0 = read.
req_addr_i  in  ADDR_W  byte address.
req_wdata_i  in  WIDTH  write data.
req_be_i  in  WIDTH/8  byte enables (writes only).
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  response ready.
rsp_rdata_o  out  WIDTH  read data; 0 for writes and errors.
rsp_err_o  out  1  1 = request rejected (misaligned or out of range).
mem_en_o  out  1  to memory a_en_i.
mem_we_o  out  1  to memory a_we_i.
mem_addr_o  out  $clog2(DEPTH)  to memory a_addr_i (word index).
mem_wdata_o  out  WIDTH  to memory a_wdata_i.
mem_be_o  out  WIDTH/8  to memory a_be_i.
mem_rdata_i  in  WIDTH  from memory a_rdata_o.

Behaviour:
- Acceptance and ordering:
  - A request is accepted when req_valid_i and req_ready_o are both high.
  - Every accepted request produces exactly one response, in order.
- Address decode, with OFF = log2(WIDTH/8):
  - word index = req_addr_i >> OFF.
  - err = (req_addr_i[OFF-1:0] != 0) or (word index >= DEPTH).
- Memory issue (combinational, same cycle as accept):
  - mem_en_o = accept and not err.
  - mem_we_o = req_we_i.
  - mem_addr_o = low bits of the word index.
  - mem_wdata_o and mem_be_o pass through from the request.
  - Rejected requests never touch memory.
  - A write with be = 0 is still issued (no-op in memory) and responded to normally.
- Pending stage:
  - Registers {valid, we, err} of the request accepted in the previous cycle.
  - When pending.valid, the FIFO push happens that cycle: rdata = (pending.we or pending.err) ? 0 : mem_rdata_i, err = pending.err.
  - mem_rdata_i is sampled only in that cycle, since the memory holds stale data when not enabled.
- Credit rule:
  - req_ready_o = !rst_i and (pending.valid + fifo_count) < RSP_DEPTH.
  - Registered terms only; there is no combinational path from rsp_ready_i or req_valid_i to req_ready_o.
  - This guarantees the FIFO can never overflow.
- Latency:
  - Accept in cycle N → FIFO push at end of N+1 → rsp_valid_o high in N+2 (2 cycles).
  - Responses are presented from the FIFO head: rsp_valid_o = fifo not empty.
  - rsp_rdata_o and rsp_err_o stay stable while rsp_valid_o is high and rsp_ready_i is low.
- Simultaneous events:
  - FIFO push and pop in the same cycle leave the count unchanged; pushing into an empty FIFO while popping is not possible (pop requires not-empty).
  - FIFO pointers wrap modulo RSP_DEPTH; RSP_DEPTH need not be a power of 2.
- Reset (asynchronous, any time):
  - Clears pending.valid, FIFO pointers and count, and any in-flight response.
  - Outputs during and after reset: req_ready_o = 0 while rst_i is high, then 1 after release; rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0; mem_en_o = 0, mem_we_o = 0.
  - mem_addr_o, mem_wdata_o and mem_be_o follow the request inputs, with no registered reset value.
  - A response in flight at reset is discarded; memory contents are unaffected.

Test Plan:
- Single write then read: write addr 0x10, data 0xDEADBEEF, be = 0xF; then read 0x10 → write response rdata = 0, err = 0; read response rdata = 0xDEADBEEF, 2 cycles after its accept.
- Partial write: write 0x20 = 0xFFFFFFFF, then 0x20 = 0x00000000 with be = 0b0101; read 0x20 → 0xFF00FF00.
- Errors: read addr 0x3 (misaligned) and read 0x400 (index 256 with DEPTH = 256) → err = 1, rdata = 0, mem_en_o never asserted; the next valid read returns correct data.
- Throughput and backpressure: 8 back-to-back reads with rsp_ready_i = 1 → 8 accepts in 8 consecutive cycles. Then rsp_ready_i = 0 → req_ready_o drops after 4 accepts, with no response lost or reordered.
- Reset mid-operation: 3 reads accepted and rsp_ready_i = 0, then assert rst_i → rsp_valid_o = 0 and req_ready_o = 0 immediately. After release, only new requests get responses.
- Random traffic: 10k random read/write/error requests with random rsp_ready_i, checked against a scoreboard memory model → every response matches in order, no FIFO overflow.

Source files
------------

// File: rtl/mem_req_adapter.sv
// mem_req_adapter: bridges a valid/ready byte-addressed request/response bus
// onto port A of the single-port on-chip memory, with a response FIFO.
//
// Ports:
//   clk_i, rst_i        clock and asynchronous active-high reset
//   req_valid_i/ready_o request handshake; req_we_i, req_addr_i (byte address),
//                       req_wdata_i, req_be_i carry the request
//   rsp_valid_o/ready_i response handshake; rsp_rdata_o, rsp_err_o carry it
//   mem_en_o, mem_we_o, mem_addr_o (word index), mem_wdata_o, mem_be_o drive
//                       memory port A; mem_rdata_i is its registered read data
module mem_req_adapter #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 256,
   parameter int ADDR_W    = 32,
   parameter int RSP_DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_we_i,
   input  logic [ADDR_W-1:0]        req_addr_i,
   input  logic [WIDTH-1:0]         req_wdata_i,
   input  logic [WIDTH/8-1:0]       req_be_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [WIDTH-1:0]         rsp_rdata_o,
   output logic                     rsp_err_o,
   output logic                     mem_en_o,
   output logic                     mem_we_o,
   output logic [$clog2(DEPTH)-1:0] mem_addr_o,
   output logic [WIDTH-1:0]         mem_wdata_o,
   output logic [WIDTH/8-1:0]       mem_be_o,
   input  logic [WIDTH-1:0]         mem_rdata_i
);

   localparam int NB  = WIDTH / 8;
   localparam int OFF = $clog2(NB);
   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = $clog2(RSP_DEPTH);
   localparam int CW  = $clog2(RSP_DEPTH + 1) + 1;

   logic [ADDR_W-1:0] off_mask;
   logic [ADDR_W-1:0] widx;
   logic              misaligned;
   logic              out_of_range;
   logic              err;
   logic              accept;

   logic              pend_valid;
   logic              pend_we;
   logic              pend_err;

   logic [WIDTH:0]    fifo_mem [RSP_DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;
   logic [CW-1:0]     used;
   logic              push;
   logic              pop;
   logic [WIDTH-1:0]  push_data;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // ---------------- address decode ----------------
   assign off_mask     = ADDR_W'((1 << OFF) - 1);
   assign widx         = req_addr_i >> OFF;
   assign misaligned   = |(req_addr_i & off_mask);
   assign out_of_range = widx >= ADDR_W'(DEPTH);
   assign err          = misaligned | out_of_range;

   // ---------------- credit / accept ----------------
   // Every slot already owed a response (in the pending stage or queued)
   // consumes a FIFO credit, so a push can never find the FIFO full.
   assign used        = count + CW'(pend_valid);
   assign req_ready_o = !rst_i && (used < CW'(RSP_DEPTH));
   assign accept      = req_valid_i && req_ready_o;

   // ---------------- memory issue ----------------
   assign mem_en_o    = accept && !err;
   assign mem_we_o    = req_we_i && !rst_i;
   assign mem_addr_o  = widx[AW-1:0];
   assign mem_wdata_o = req_wdata_i;
   assign mem_be_o    = req_be_i;

   // ---------------- pending stage ----------------
   // Tracks the request accepted last cycle while the memory read completes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_valid <= 1'b0;
         pend_we    <= 1'b0;
         pend_err   <= 1'b0;
      end else begin
         pend_valid <= accept;
         pend_we    <= req_we_i;
         pend_err   <= err;
      end
   end

   // mem_rdata_i is only meaningful in the cycle after an enabled read.
   assign push      = pend_valid;
   assign push_data = (pend_we || pend_err) ? '0 : mem_rdata_i;

   // ---------------- response FIFO ----------------
   assign rsp_valid_o = count != '0;
   assign pop         = rsp_valid_o && rsp_ready_i;

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[tail] <= {pend_err, push_data};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= wrap_inc(tail);
         end
         if (pop) begin
            head <= wrap_inc(head);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Gate the head so the response outputs read zero when nothing is queued.
   assign rsp_rdata_o = rsp_valid_o ? fifo_mem[head][WIDTH-1:0] : '0;
   assign rsp_err_o   = rsp_valid_o && fifo_mem[head][WIDTH];

endmodule

// File: tb/tb_mem_req_adapter.sv
// tb_mem_req_adapter: self-checking bench for mem_req_adapter with a
// behavioural memory, a queue-based response scoreboard and directed tables.
module tb_mem_req_adapter;

   localparam int RSP_D = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;

   mem_req_adapter #(
      .WIDTH(32), .DEPTH(256), .ADDR_W(32), .RSP_DEPTH(RSP_D)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
      .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   // physical memory: one-cycle registered read, byte-enabled write
   logic [31:0] marr [256];
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we && mem_be[b]) marr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= marr[mem_addr];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          stamp;
   } exp_t;

   logic [31:0] ref_mem [256];
   exp_t        exp_q [$];
   exp_t        e_m;
   int          cyc = 0;
   logic        acc_m, bad_m, hold_m;
   logic [31:0] idx_m;
   logic [32:0] prev_m;

   initial begin
      for (int i = 0; i < 256; i++) begin
         marr[i]    = '0;
         ref_mem[i] = '0;
      end
   end

   // Samples once per cycle, 2 ns before the rising edge.
   always begin
      @(negedge clk);
      #3;
      cyc++;
      if (rst) begin
         exp_q.delete();
         hold_m = 1'b0;
      end else begin
         chk("req_ready", req_ready, exp_q.size() < RSP_D);
         chk("rsp_valid", rsp_valid,
             exp_q.size() > 0 && exp_q[0].stamp + 2 <= cyc);
         if (hold_m && rsp_valid)
            chk("rsp_stable", {rsp_err, rsp_rdata}, prev_m);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               e_m = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, e_m.rdata);
               chk("rsp_err", rsp_err, e_m.err);
            end
         end
         acc_m = req_valid && req_ready;
         idx_m = req_addr / 4;
         bad_m = (req_addr % 4 != 0) || (idx_m >= 256);
         chk("mem_en", mem_en, acc_m && !bad_m);
         if (acc_m && !bad_m)
            chk("mem_port", {mem_we, mem_addr, mem_wdata, mem_be},
                {req_we, idx_m[7:0], req_wdata, req_be});
         if (acc_m) begin
            e_m.rdata = '0;
            e_m.err   = bad_m;
            e_m.stamp = cyc;
            if (!bad_m) begin
               if (req_we) begin
                  for (int b = 0; b < 4; b++)
                     if (req_be[b]) ref_mem[idx_m][8*b +: 8] = req_wdata[8*b +: 8];
               end else begin
                  e_m.rdata = ref_mem[idx_m];
               end
            end
            exp_q.push_back(e_m);
         end
         hold_m = rsp_valid && !rsp_ready;
         prev_m = {rsp_err, rsp_rdata};
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic send(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
      int k;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_be    = b;
      k = 0;
      while (k < 50) begin
         #3;
         if (req_ready) break;
         @(negedge clk);
         k++;
      end
      if (k == 50) chk("accept_timeout", 0, 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat);
      lat = 1;
      rd  = '0;
      er  = 1'b0;
      while (lat < 20) begin
         #3;
         if (rsp_valid) begin
            rd = rsp_rdata;
            er = rsp_err;
            break;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      rsp_ready = 1'b1;
      while (k < 100 && (exp_q.size() != 0 || rsp_valid)) begin
         @(negedge clk);
         k++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t        tbl [15];
   logic [31:0] rd;
   logic        er;
   int          lat;
   int          n_acc;
   int          sent;
   int          ncyc;
   logic        acc_last;

   initial begin
      tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 32'h20,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
      tbl[3]  = '{1'b1, 32'h20,  32'h00000000, 4'h5, 32'h0,        1'b0};
      tbl[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'hFF00FF00, 1'b0};
      tbl[5]  = '{1'b0, 32'h3,   32'h0,        4'h0, 32'h0,        1'b1};
      tbl[6]  = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1};
      tbl[7]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      tbl[8]  = '{1'b1, 32'h22,  32'h12345678, 4'hF, 32'h0,        1'b1};
      tbl[9]  = '{1'b1, 32'h10,  32'h0,        4'h0, 32'h0,        1'b0};
      tbl[10] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      tbl[11] = '{1'b1, 32'h3FC, 32'hA5A50001, 4'hF, 32'h0,        1'b0};
      tbl[12] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hA5A50001, 1'b0};
      tbl[13] = '{1'b1, 32'hFFFFFFFC, 32'h1,   4'hF, 32'h0,        1'b1};
      tbl[14] = '{1'b0, 32'h20,  32'h0,        4'h0, 32'hFF00FF00, 1'b0};

      // reset state, with a write request presented to check gating
      req_valid = 1'b1;
      req_we    = 1'b1;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      req_valid = 1'b0;
      req_we    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", req_ready, 1);
      chk("post_rst_valid", rsp_valid, 0);

      // directed table, one transaction at a time
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         send(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);
         wait_rsp(rd, er, lat);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
         chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
         chk($sformatf("tbl%0d_lat", i), lat, 2);
      end
      @(negedge clk);
      drain();

      // throughput: 8 back-to-back reads
      @(negedge clk);
      n_acc = 0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      for (int i = 0; i < 8; i++) begin
         req_addr = 32'(i * 4);
         #3;
         if (req_ready) n_acc++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_accepts", n_acc, 8);
      drain();

      // backpressure: credits run out after RSP_D accepts
      @(negedge clk);
      rsp_ready = 1'b0;
      n_acc = 0;
      req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_addr = 32'h20 + 32'(i % 2) * 32'h3DC;
         #3;
         if (req_ready) n_acc++;
         @(negedge clk);
      end
      #3;
      chk("bp_ready_low", req_ready, 0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_accepts", n_acc, RSP_D);
      drain();

      // reset mid-operation
      @(negedge clk);
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b0, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("pre_rst_valid", rsp_valid, 1);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h10;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_rdata", rsp_rdata, 0);
      chk("mid_rst_mem_en", mem_en, 0);
      chk("mid_rst_mem_we", mem_we, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      rsp_ready = 1'b1;
      #1;
      chk("rel_ready", req_ready, 1);
      chk("rel_valid", rsp_valid, 0);
      @(negedge clk);
      send(1'b0, 32'h20, 32'h0, 4'h0);
      wait_rsp(rd, er, lat);
      chk("after_rst_rdata", rd, 32'hFF00FF00);
      chk("after_rst_lat", lat, 2);
      @(negedge clk);
      drain();

      // random traffic with random response backpressure
      sent = 0;
      ncyc = 0;
      acc_last = 1'b0;
      while (sent < 10000 && ncyc < 60000) begin
         @(negedge clk);
         ncyc++;
         if (req_valid && acc_last) req_valid = 1'b0;
         if (!req_valid && $urandom_range(0, 3) != 0) begin
            req_valid = 1'b1;
            req_we    = $urandom_range(0, 1) == 1;
            req_wdata = $urandom;
            req_be    = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
               0:       req_addr = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(1, 3));
               1:       req_addr = ($urandom | 32'h400) & 32'hFFFF_FFFC;
               2:       req_addr = 32'($urandom_range(0, 255)) * 4;
               default: req_addr = 32'($urandom_range(0, 15)) * 4;
            endcase
         end
         rsp_ready = $urandom_range(0, 3) != 0;
         #3;
         acc_last = req_valid && req_ready;
         if (acc_last) sent++;
      end
      chk("rand_sent", sent, 10000);
      @(negedge clk);
      req_valid = 1'b0;
      drain();

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
